// File: rtl/camera_capture_writer_if.sv
// rtl/camera_capture_writer_if.sv - camera byte stream in, frame store pixel write port out
// master: capture block side; slave: camera/frame-store environment side.
interface camera_capture_writer_if #(
    parameter int ADDR_WIDTH = 19
);
    logic                  cam_vsync;
    logic                  cam_href;
    logic [7:0]            cam_data;
    logic                  cam_strobe;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [15:0]           write_rgb;
    logic                  write_mask;
    logic                  write_enable;
    logic                  frame_done;
    logic                  frame_err;
    logic [7:0]            frame_count;

    modport master (
        input  cam_vsync, cam_href, cam_data, cam_strobe,
        output write_addr, write_rgb, write_mask, write_enable,
        output frame_done, frame_err, frame_count
    );

    modport slave (
        output cam_vsync, cam_href, cam_data, cam_strobe,
        input  write_addr, write_rgb, write_mask, write_enable,
        input  frame_done, frame_err, frame_count
    );
endinterface

// File: rtl/camera_capture_writer.sv
// rtl/camera_capture_writer.sv - RGB565 byte-stream capture into linear frame store writes
// Optional skin classifier on write_mask: define SKIN_DETECT_EN.
module camera_capture_writer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    camera_capture_writer_if.master bus
);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0]         COL_MAX   = CW'(H_ACTIVE);
    localparam logic [LW-1:0]         LINE_MAX  = LW'(V_ACTIVE);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_ACTIVE);

    typedef enum logic [1:0] {SYNC, WAIT_START, ACTIVE, DONE} state_t;
    state_t state, state_nxt;

    logic                  vsync_q, href_q, vsync_fall, href_fall;
    logic                  st_start, st_capture, st_done;
    logic                  phase, short_line, line_over;
    logic [7:0]            hi_byte;
    logic [CW-1:0]         col;
    logic [LW-1:0]         line;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [15:0]           pixel;
    logic                  pixel_mask, byte_en, pixel_en, line_end, write_ok, frame_bad;

    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [15:0]           wr_rgb_q;
    logic                  wr_mask_q, wr_en_q, done_q, err_q;
    logic [7:0]            count_q;

    assign vsync_fall = vsync_q & ~bus.cam_vsync;
    assign href_fall  = href_q & ~bus.cam_href;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:       if (bus.cam_vsync) state_nxt = WAIT_START;
            WAIT_START: if (vsync_fall)    state_nxt = ACTIVE;
            ACTIVE:     if (bus.cam_vsync) state_nxt = DONE;
            DONE:                          state_nxt = WAIT_START;
            default:                       state_nxt = SYNC;
        endcase
    end

    always_comb begin
        st_start   = 1'b0;
        st_capture = 1'b0;
        st_done    = 1'b0;
        case (state)
            WAIT_START: st_start   = vsync_fall;
            ACTIVE:     st_capture = ~bus.cam_vsync;
            DONE:       st_done    = 1'b1;
            default:    ;
        endcase
    end

    assign byte_en   = st_capture & bus.cam_href & bus.cam_strobe;
    assign pixel_en  = byte_en & phase;
    // col saturates at H_ACTIVE, so nonzero means the line saw at least one pixel
    assign line_end  = st_capture & href_fall & (col != '0);
    assign write_ok  = (col != COL_MAX) && (line != LINE_MAX);
    assign pixel     = {hi_byte, bus.cam_data};
    assign frame_bad = short_line | line_over | (line != LINE_MAX);

`ifdef SKIN_DETECT_EN
    logic [7:0] r8, g8, b8;
    logic [8:0] rg_diff;
    assign r8      = {pixel[15:11], pixel[15:13]};
    assign g8      = {pixel[10:5], pixel[10:9]};
    assign b8      = {pixel[4:0], pixel[4:2]};
    assign rg_diff = {1'b0, r8} - {1'b0, g8};
    assign pixel_mask = (r8 > 8'd95) && (g8 > 8'd40) && (b8 > 8'd20) &&
                        (r8 > g8) && (r8 > b8) && (rg_diff > 9'd15);
`else
    assign pixel_mask = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            col        <= '0;
            line       <= '0;
            line_base  <= '0;
            short_line <= 1'b0;
            line_over  <= 1'b0;
            wr_addr_q  <= '0;
            wr_rgb_q   <= '0;
            wr_mask_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            vsync_q <= bus.cam_vsync;
            href_q  <= bus.cam_href;
            wr_en_q <= 1'b0;
            done_q  <= st_done;
            err_q   <= st_done & frame_bad;
            if (st_done) count_q <= count_q + 8'd1;
            if (st_start) begin
                phase      <= 1'b0;
                col        <= '0;
                line       <= '0;
                line_base  <= '0;
                short_line <= 1'b0;
                line_over  <= 1'b0;
            end else begin
                if (href_fall)    phase <= 1'b0;
                else if (byte_en) phase <= ~phase;
                if (byte_en && !phase) hi_byte <= bus.cam_data;
                if (pixel_en) begin
                    if (write_ok) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= line_base + ADDR_WIDTH'(col);
                        wr_rgb_q  <= pixel;
                        wr_mask_q <= pixel_mask;
                    end
                    if (col != COL_MAX) col <= col + 1'b1;
                end
                if (line_end) begin
                    col <= '0;
                    if (col != COL_MAX) short_line <= 1'b1;
                    // line saturates; line_over remembers that extra lines were seen
                    if (line != LINE_MAX) begin
                        line      <= line + 1'b1;
                        line_base <= line_base + LINE_STEP;
                    end else begin
                        line_over <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.write_addr   = wr_addr_q;
    assign bus.write_rgb    = wr_rgb_q;
    assign bus.write_mask   = wr_mask_q;
    assign bus.write_enable = wr_en_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_err    = err_q;
    assign bus.frame_count  = count_q;
endmodule

// File: tb/tb_camera_capture_writer.sv
// tb/tb_camera_capture_writer.sv - randomized scoreboard bench for camera_capture_writer
// Small geometry (4x2) keeps frames short; expected writes/frames are queued by the stimulus.
module tb_camera_capture_writer;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 19;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   rgb;
        logic          mask;
    } wr_t;

    typedef struct packed {
        logic       err;
        logic [7:0] cnt;
    } fr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    camera_capture_writer_if #(.ADDR_WIDTH(AW)) bus ();

    camera_capture_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wr_t  exp_wr[$];
    fr_t  exp_fr[$];
    int   errors = 0;
    int   checks = 0;
    int   wr_seen = 0;
    logic [7:0] fc = 8'd0;
    int   line_bytes[8];
    int   max_gap = 2;

    function automatic logic skin(input logic [15:0] p);
`ifdef SKIN_DETECT_EN
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return (r8 > 95) && (g8 > 40) && (b8 > 20) && (r8 > g8) && (r8 > b8) && (r8 - g8 > 15);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] pick_byte(input int mode, input int b);
        if (mode == 0) return (b % 2 == 0) ? 8'hF8 : 8'h00;
        if (mode == 1) return (b % 2 == 0) ? 8'hD3 : 8'h27;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one frame; the model derives expected writes from byte counts per line.
    task automatic run_frame(input int nlines, input int mode, input bit hold_last, input int abort_line);
        int ended = 0;
        bit short_f = 1'b0;
        logic [7:0] hi = 8'h00;
        logic [7:0] d;
        bus.cam_vsync = 1'b1;
        repeat (3) @(negedge clk);
        bus.cam_vsync = 1'b0;
        repeat (2) @(negedge clk);
        for (int l = 0; l < nlines; l++) begin
            int pix = 0;
            bus.cam_href = 1'b1;
            @(negedge clk);
            for (int b = 0; b < line_bytes[l]; b++) begin
                if (l == abort_line && b == 2) begin
                    repeat (2) @(negedge clk);
                    rst_n = 1'b0;
                    repeat (3) @(negedge clk);
                    bus.cam_href = 1'b0;
                    fc = 8'd0;
                    rst_n = 1'b1;
                    return;
                end
                d = pick_byte(mode, b);
                if (b % 2 == 0) hi = d;
                else begin
                    if (pix < H && ended < V)
                        exp_wr.push_back('{addr: AW'(ended * H + pix), rgb: {hi, d}, mask: skin({hi, d})});
                    pix++;
                end
                bus.cam_data   = d;
                bus.cam_strobe = 1'b1;
                @(negedge clk);
                bus.cam_strobe = 1'b0;
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
            end
            if (!(hold_last && l == nlines - 1)) begin
                bus.cam_href = 1'b0;
                if (pix > 0) begin
                    ended++;
                    if (pix < H) short_f = 1'b1;
                end
                repeat (2) @(negedge clk);
            end
        end
        fc = fc + 8'd1;
        exp_fr.push_back('{err: short_f || (ended != V), cnt: fc});
        bus.cam_vsync = 1'b1;
        repeat (2) @(negedge clk);
        bus.cam_href = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_lines(input int a, input int b, input int c);
        line_bytes[0] = a;
        line_bytes[1] = b;
        line_bytes[2] = c;
    endtask

    always @(negedge clk) begin
        if (bus.write_enable) begin
            wr_seen++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d rgb=%h", bus.write_addr, bus.write_rgb);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                if ({bus.write_addr, bus.write_rgb, bus.write_mask} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%0d rgb=%h mask=%b expected addr=%0d rgb=%h mask=%b",
                             bus.write_addr, bus.write_rgb, bus.write_mask, e.addr, e.rgb, e.mask);
                end
            end
        end
        if (bus.frame_done) begin
            checks++;
            if (exp_fr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_done: count=%0d", bus.frame_count);
            end else begin
                fr_t f;
                f = exp_fr.pop_front();
                if ({bus.frame_err, bus.frame_count} !== f) begin
                    errors++;
                    $display("FAIL frame: got err=%b count=%0d expected err=%b count=%0d",
                             bus.frame_err, bus.frame_count, f.err, f.cnt);
                end
            end
        end
        if (bus.frame_err && !bus.frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_err_alone: got 1 expected 0");
        end
    end

    initial begin
        int w0;
        bus.cam_vsync  = 1'b0;
        bus.cam_href   = 1'b0;
        bus.cam_data   = 8'h00;
        bus.cam_strobe = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_write_addr", int'(bus.write_addr), 0);
        chk("rst_write_rgb", int'(bus.write_rgb), 0);
        chk("rst_write_mask", int'(bus.write_mask), 0);
        chk("rst_write_enable", int'(bus.write_enable), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        chk("rst_frame_err", int'(bus.frame_err), 0);
        chk("rst_frame_count", int'(bus.frame_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_lines(8, 8, 0);   run_frame(2, 0, 1'b0, -1);   // nominal red
        set_lines(8, 8, 0);   run_frame(2, 1, 1'b0, -1);   // skin pixel
        set_lines(14, 4, 0);  run_frame(2, 2, 1'b0, -1);   // oversize then short
        set_lines(3, 8, 8);   run_frame(3, 2, 1'b0, -1);   // odd byte count
        set_lines(1, 8, 8);   run_frame(3, 2, 1'b0, -1);   // single-byte line never ends
        set_lines(8, 8, 8);   run_frame(3, 2, 1'b0, -1);   // too many lines
        set_lines(8, 8, 8);   run_frame(3, 2, 1'b1, -1);   // vsync with href high
        set_lines(8, 5, 0);   run_frame(2, 2, 1'b1, -1);
        for (int i = 0; i < 20; i++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int l = 0; l < n; l++) line_bytes[l] = $urandom_range(0, 12);
            run_frame(n, 2, 1'($urandom_range(0, 1)), -1);
        end

        // reset mid-frame, released while vsync is low
        set_lines(8, 8, 0);   run_frame(2, 2, 1'b0, 1);
        @(negedge clk);
        chk("post_rst_write_enable", int'(bus.write_enable), 0);
        chk("post_rst_frame_count", int'(bus.frame_count), 0);
        chk("post_rst_write_addr", int'(bus.write_addr), 0);
        w0 = wr_seen;
        bus.cam_href = 1'b1;
        for (int b = 0; b < 8; b++) begin
            bus.cam_data = 8'($urandom_range(0, 255));
            bus.cam_strobe = 1'b1;
            @(negedge clk);
            bus.cam_strobe = 1'b0;
        end
        bus.cam_href = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_write_before_vsync", wr_seen - w0, 0);
        set_lines(8, 8, 0);   run_frame(2, 2, 1'b0, -1);

        // frame counter wrap with back-to-back strobes
        max_gap = 0;
        for (int i = 0; i < 256; i++) begin
            set_lines(8, 8, 0);
            run_frame(2, 2, 1'b0, -1);
        end

        for (int t = 0; t < 100 && (exp_wr.size() != 0 || exp_fr.size() != 0); t++) @(negedge clk);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_frames", exp_fr.size(), 0);
        chk("final_frame_count", int'(bus.frame_count), int'(fc));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/camera_capture_writer.md
# camera_capture_writer

- Camera-side producer for the double-buffered frame store: turns a byte-serial RGB565 camera stream (OV7670-style VSYNC/HREF/byte strobe) into one write per pixel.
- Each write carries a linear address, 16-bit pixel and skin-mask bit.
- Pulses `frame_done` at each frame boundary so the store swaps buffers.
- Sits between the camera input synchronizer and the frame buffer write port, in the single `clk` domain.

## Interface
Parameters:
- `H_ACTIVE`, 640, pixels per line written to the store
- `V_ACTIVE`, 480, lines per frame written to the store
- `ADDR_WIDTH`, 19, width of `write_addr`

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `cam_vsync`  in  1  frame sync, high between frames, already synchronized to `clk`
- `cam_href`  in  1  line valid, already synchronized
- `cam_data`  in  8  camera byte, valid when `cam_strobe`=1
- `cam_strobe`  in  1  one-cycle pulse per received byte
- `write_addr`  out  ADDR_WIDTH  linear pixel address, line*H_ACTIVE+col
- `write_rgb`  out  16  RGB565 pixel
- `write_mask`  out  1  skin-mask bit
- `write_enable`  out  1  one-cycle write strobe
- `frame_done`  out  1  one-cycle pulse at end of a captured frame
- `frame_err`  out  1  one-cycle pulse with `frame_done` if the frame geometry was wrong
- `frame_count`  out  8  completed frames, wraps 255->0

## Operation
States:
- **SYNC**
  - Entered from reset.
  - Waits for `cam_vsync`=1, then goes to **WAIT_START**.
  - Ignores all bytes.
- **WAIT_START**
  - On `cam_vsync` falling edge: clear column, line and address counters and the short-line flag, then go to **ACTIVE**.
- **ACTIVE**
  - Capture bytes while `cam_href`=1.
  - On `cam_vsync` rising edge, go to **DONE**.
- **DONE**
  - Lasts one cycle: pulse `frame_done`, pulse `frame_err` if needed, increment `frame_count`.
  - Then go to **WAIT_START**.

Byte assembly:
- A phase bit toggles on each `cam_strobe` with `cam_href`=1.
- Phase 0 latches the high byte, `rgb[15:8]`. Phase 1 completes the pixel with `rgb[7:0]`.
- The phase bit clears on `cam_href` falling edge. A dangling high byte is discarded.

Geometry:
- Pixels with column >= H_ACTIVE, or in lines with line >= V_ACTIVE, are counted but not written.
- The address counter advances only on a written pixel.
- Each write uses `write_addr` = line_base + col, where line_base increments by H_ACTIVE per line. No multiplier.
- On `cam_href` falling edge, a line is ended only if at least one pixel was received on it:
  - line increments, saturating at V_ACTIVE;
  - column clears;
  - if fewer than H_ACTIVE pixels were received, the short-line flag is set.
- `frame_err` = short-line flag set, or the number of ended lines != V_ACTIVE.

Skin mask:
- Expand the pixel to 8 bits per channel: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- mask = R8>95 && G8>40 && B8>20 && R8>G8 && R8>B8 && (R8-G8)>15.
- The subtraction is 9-bit, so it cannot wrap.

Boundary conditions:
- **`cam_vsync` rises with `cam_href` still high:** treat as end of frame. A pending half pixel is discarded.
- **`cam_strobe` with `cam_href`=0:** ignored.
- **Reset mid-frame:** all outputs clear and the FSM returns to **SYNC**. A partial frame is never written, because capture needs a full vsync high-then-low.

## Timing
- Reset values: `write_addr`=0, `write_rgb`=0, `write_mask`=0, `write_enable`=0, `frame_done`=0, `frame_err`=0, `frame_count`=0.
- `write_enable`, `write_addr`, `write_rgb` and `write_mask` are registered together. They assert exactly 1 cycle after the phase-1 `cam_strobe`.
- `frame_done` asserts 1 cycle after the `clk` edge where synchronized `cam_vsync` is first seen high in **ACTIVE**.
- The last pixel's write never coincides with `frame_done`: the vsync edge is detected no earlier than the cycle after the final strobe.
- Back-to-back strobes (every cycle) must be supported. Throughput is 1 pixel per 2 strobes.

## Configuration
`SKIN_DETECT_EN`:
- **Defined:** `write_mask` carries the skin classifier result, with the same 1-cycle latency as `write_rgb`.
- **Undefined:** the classifier logic is removed and `write_mask` is constant 0. All other behaviour is unchanged.

## Test plan
1. **Nominal frame:** vsync high, then low; 480 lines of 640 pixels, bytes 0xF8,0x00 (pure red); vsync high.
   - 307200 writes, addresses 0..307199 with no gaps.
   - `write_rgb`=0xF800, `write_mask`=0 (G8=0 fails G8>40).
   - One `frame_done`, `frame_err`=0, `frame_count`=1.
2. **Skin pixel:** bytes 0xD3,0x27 (R5=26, G6=25, B5=7).
   - `write_rgb`=0xD327, `write_mask`=1 with `SKIN_DETECT_EN`, 0 without.
3. **Oversize and short geometry:** lines of 700 pixels, then one line of 100 pixels.
   - Only columns 0..639 are written on the long lines.
   - The short line writes 100 pixels.
   - `frame_err`=1 at `frame_done`.
4. **Odd byte count:** line ends after 3 bytes.
   - One write; the third byte is discarded.
   - The next line's first byte is treated as a high byte.
5. **Reset mid-frame:** `rst_n`=0 at line 200, then released while vsync is low.
   - All outputs 0 and no writes until vsync toggles high then low.
   - The next frame starts at `write_addr`=0.
6. **Frame counter wrap:** 256 frames of 4x2 pixels with H_ACTIVE=4, V_ACTIVE=2.
   - `frame_count` wraps 255->0.
   - Exactly one `frame_done` per vsync rise.
